mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access (MA) stage logic between the EX/MA pipeline register and the MA/WB register.
- Decodes load/store from Instr_M and drives a single-outstanding data-memory bus with a req/ready handshake.
- Aligns store data into byte lanes, and extracts plus sign- or zero-extends load data.
- Stalls the pipeline while a transfer is outstanding. Presents Read_Data_M to the MA/WB register.

Parameters:
- TIMEOUT, 16: max REQ-state cycles without mem_ready before the bus error is declared (>=1).
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- valid_M  in  1  MA stage holds a live instruction
- Instr_M  in  32  instruction in MA; opcode [6:0], funct3 [14:12]
- ALU_Result_M  in  32  effective address
- Write_Data_M  in  32  store source (rs2)
- mem_req  out  1  bus request
- mem_we  out  1  1=store, 0=load
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned store data
- mem_ready  in  1  bus completes the transfer this cycle
- mem_rdata  in  32  read word, valid when mem_ready=1
- Read_Data_M  out  32  extended load result, to MA/WB
- Stall_M  out  1  freeze PC, IF/ID, ID/EX and EX/MA; MA/WB receives a bubble
- Misalign_M  out  1  misaligned access flag (combinational)
- Bus_Err_M  out  1  timeout flag, one cycle, in DONE

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values: state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, Read_Data_M=0, Bus_Err_M=0, counter=0. Stall_M=0 and Misalign_M=0 while rst=1.
- Decode:
  - load = opcode 0000011; store = opcode 0100011.
  - funct3 000=B, 001=H, 010=W, 100=BU, 101=HU.
  - Any other funct3 is treated as W.
- Misaligned access: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Misalign_M=1 combinationally in IDLE.
  - No request is issued and Stall_M=0; the instruction passes.
- mem_op = valid_M & (load|store) & ~misaligned.
- Store lanes:
  - B: be=0001<<addr[1:0]; wdata = byte replicated x4.
  - H: be=0011<<addr[1:0]; wdata = half replicated x2.
  - W: be=1111.
- Loads: be per the same rule.
  - Result byte/half is selected by addr[1:0].
  - B/H sign-extend; BU/HU zero-extend.
- FSM:
  - IDLE:
    - Stall_M = mem_op.
    - If mem_op, at the edge latch mem_addr/be/wdata/we, funct3 and addr[1:0]; clear the counter; go to REQ.
    - Otherwise stay in IDLE.
  - REQ:
    - mem_req=1, Stall_M=1; outputs stable.
    - If mem_ready=1 at the edge: a load captures the extended mem_rdata into Read_Data_M; go to DONE.
    - Else if counter==TIMEOUT-1: Bus_Err_M<=1; Read_Data_M is unchanged; go to DONE.
    - Else counter+1.
  - DONE:
    - mem_req=0, Stall_M=0; the pipeline advances at this edge.
    - Bus_Err_M deasserts the next cycle. Go to IDLE.
- Minimum load/store occupancy is 3 cycles (IDLE, REQ, DONE) with 2 stall cycles. Each extra REQ wait cycle adds 1.
- Read_Data_M holds its last value except on load capture. Stores and non-memory instructions do not change it.
- mem_ready outside REQ is ignored.
- Back-to-back memory ops: the second is evaluated in the IDLE cycle following DONE. There is no overlap.
- Reset during REQ: mem_req drops immediately (async) and the transfer is abandoned. The bus must tolerate the dropped request.
- Exactly one outstanding transfer at any time.

Test Plan:
- LW addr 0x100, mem_ready on the first REQ cycle, rdata=0xDEADBEEF -> Stall_M high 2 cycles, mem_be=1111, mem_addr=0x100, Read_Data_M=0xDEADBEEF in DONE.
- LB addr 0x103, rdata=0x80FF0000 -> be=1000, Read_Data_M=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
- SB addr 0x201, rs2=0x123456AB, 3 wait cycles -> mem_we=1, be=0010, wdata=0xABABABAB, stall held 5 cycles, Read_Data_M unchanged.
- LW addr 0x102 -> Misalign_M=1 same cycle, mem_req never asserted, Stall_M=0. SH addr 0x101 -> same.
- Load with mem_ready held low, TIMEOUT=16 -> 16 REQ cycles, Bus_Err_M=1 for exactly one cycle, then IDLE.
- rst pulsed on the 2nd REQ cycle -> mem_req=0 and Stall_M=0 immediately. After release, a new LW completes normally. ADD (non-memory) -> Stall_M=0, no request.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Single-outstanding data-memory bus between the MA stage (master) and data memory (slave).
// A transfer completes in the cycle mem_ready is high while mem_req is high.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: decodes loads/stores, runs one bus transfer at a time,
// lane-aligns store data, extends load data and stalls the pipeline while busy.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_M,
  input  logic [31:0]             Instr_M,
  input  logic [31:0]             ALU_Result_M,
  input  logic [31:0]             Write_Data_M,
  mem_access_stage_if.master      bus,
  output logic [31:0]             Read_Data_M,
  output logic                    Stall_M,
  output logic                    Misalign_M,
  output logic                    Bus_Err_M
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e state_q, state_d;

  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [1:0]       lo_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rd_q, rd_d;
  logic             berr_q, berr_d;
  logic             latch_en;
  logic             stall;

  // Decode of the instruction currently sitting in MA
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic        is_load, is_store, is_mem;
  logic        size_byte, size_half, size_word;
  logic        misaligned;
  logic        mem_op;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{Instr_M[31:15], Instr_M[11:7]};

  assign opcode    = Instr_M[6:0];
  assign funct3    = Instr_M[14:12];
  assign addr_lo   = ALU_Result_M[1:0];
  assign is_load   = (opcode == OpLoad);
  assign is_store  = (opcode == OpStore);
  assign is_mem    = is_load | is_store;

  // funct3[1:0] picks the size; unlisted encodings fall through to word
  assign size_byte = (funct3[1:0] == 2'b00);
  assign size_half = (funct3[1:0] == 2'b01);
  assign size_word = ~size_byte & ~size_half;

  assign misaligned = (size_half & addr_lo[0]) | (size_word & (addr_lo != 2'b00));
  assign mem_op     = valid_M & is_mem & ~misaligned;

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = Write_Data_M;
    if (size_byte) begin
      be_next    = 4'b0001 << addr_lo;
      wdata_next = {4{Write_Data_M[7:0]}};
    end else if (size_half) begin
      be_next    = 4'b0011 << addr_lo;
      wdata_next = {2{Write_Data_M[15:0]}};
    end
  end

  // Load extraction uses the latched size/offset, since the bus result arrives in REQ
  logic [31:0] rdata_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;

  assign rdata_shift = bus.mem_rdata >> {lo_q, 3'b000};
  assign ld_byte     = rdata_shift[7:0];
  assign ld_half     = lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_comb begin
    load_ext = bus.mem_rdata;
    unique case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    berr_d   = 1'b0;
    latch_en = 1'b0;
    stall    = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall = mem_op;
        if (mem_op) begin
          latch_en = 1'b1;
          cnt_d    = '0;
          state_d  = StReq;
        end
      end
      StReq: begin
        stall = 1'b1;
        if (bus.mem_ready) begin
          if (!we_q) rd_d = load_ext;
          state_d = StDone;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          berr_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      berr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      berr_q  <= berr_d;
      if (latch_en) begin
        addr_q   <= {ALU_Result_M[31:2], 2'b00};
        be_q     <= be_next;
        wdata_q  <= wdata_next;
        we_q     <= is_store;
        funct3_q <= funct3;
        lo_q     <= addr_lo;
      end
    end
  end

  // mem_req decodes from state so an async reset drops it immediately
  assign bus.mem_req   = (state_q == StReq);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

  assign Read_Data_M = rd_q;
  assign Bus_Err_M   = berr_q;
  assign Stall_M     = stall & ~rst;
  assign Misalign_M  = (state_q == StIdle) & valid_M & is_mem & misaligned & ~rst;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a transaction-level model predicts every output
// per cycle, and literal expectations pin the model on the documented scenarios.
module tb_mem_access_stage;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_M;
  logic [31:0] Instr_M, ALU_Result_M, Write_Data_M;
  logic [31:0] Read_Data_M;
  logic        Stall_M, Misalign_M, Bus_Err_M;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_M      (valid_M),
    .Instr_M      (Instr_M),
    .ALU_Result_M (ALU_Result_M),
    .Write_Data_M (Write_Data_M),
    .bus          (bus),
    .Read_Data_M  (Read_Data_M),
    .Stall_M      (Stall_M),
    .Misalign_M   (Misalign_M),
    .Bus_Err_M    (Bus_Err_M)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Per-cycle model expectations
  logic        check_en = 1'b0;
  logic        exp_req, exp_stall, exp_mis, exp_berr, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_rd;
  logic [3:0]  exp_be;
  logic [31:0] model_rd = '0;

  // Observations accumulated by the compare process
  int          stall_cyc = 0, req_cyc = 0, berr_cyc = 0, mis_cyc = 0;
  logic [3:0]  last_be = '0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic        last_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en && !rst) begin
      check("req", 32'(bus.mem_req), 32'(exp_req));
      check("stall", 32'(Stall_M), 32'(exp_stall));
      check("misalign", 32'(Misalign_M), 32'(exp_mis));
      check("bus_err", 32'(Bus_Err_M), 32'(exp_berr));
      check("read_data", Read_Data_M, exp_rd);
      if (exp_req) begin
        check("addr", bus.mem_addr, exp_addr);
        check("be", 32'(bus.mem_be), 32'(exp_be));
        check("we", 32'(bus.mem_we), 32'(exp_we));
        if (exp_we) check("wdata", bus.mem_wdata, exp_wdata);
      end
    end
    if (!rst) begin
      if (Stall_M)     stall_cyc <= stall_cyc + 1;
      if (bus.mem_req) req_cyc   <= req_cyc + 1;
      if (Bus_Err_M)   berr_cyc  <= berr_cyc + 1;
      if (Misalign_M)  mis_cyc   <= mis_cyc + 1;
      if (bus.mem_req) begin
        last_be    <= bus.mem_be;
        last_addr  <= bus.mem_addr;
        last_wdata <= bus.mem_wdata;
        last_we    <= bus.mem_we;
      end
    end
  end

  // Access size in bytes from funct3
  function automatic int sz(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int v;
    v = ((1 << sz(f3)) - 1) << (addr % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (sz(f3))
      1:       return {4{wd[7:0]}};
      2:       return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int s;
    logic [31:0] v, mask;
    s    = sz(f3);
    v    = rdata >> (8 * (addr % 4));
    mask = (s == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * s)) - 32'd1;
    v    = v & mask;
    if (!f3[2] && s < 4 && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
    return {17'd0, f3, 5'd0, op};
  endfunction

  // waits < 0 means the bus never answers
  task automatic run_op(input logic [31:0] instr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata, input int waits);
    logic [6:0] op;
    logic [2:0] f3;
    logic is_mem, is_ld, mis, mop, timed_out;
    int nreq;
    op     = instr[6:0];
    f3     = instr[14:12];
    is_ld  = (op == LD);
    is_mem = is_ld || (op == ST);
    mis    = is_mem && ((addr % sz(f3)) != 0);
    mop    = is_mem && !mis;

    valid_M = 1'b1; Instr_M = instr; ALU_Result_M = addr; Write_Data_M = wd;
    bus.mem_ready = 1'b0; bus.mem_rdata = $urandom;
    exp_req = 1'b0; exp_stall = mop; exp_mis = mis; exp_berr = 1'b0; exp_rd = model_rd;
    check_en = 1'b1;
    @(posedge clk); #1;
    if (mop) begin
      exp_addr  = {addr[31:2], 2'b00};
      exp_be    = m_be(f3, addr);
      exp_wdata = m_wdata(f3, wd);
      exp_we    = !is_ld;
      exp_req = 1'b1; exp_stall = 1'b1; exp_mis = 1'b0;
      timed_out = !(waits >= 0 && waits < int'(TIMEOUT));
      nreq = timed_out ? int'(TIMEOUT) : waits + 1;
      for (int i = 0; i < nreq; i++) begin
        bus.mem_ready = (i == waits);
        bus.mem_rdata = (i == waits) ? rdata : $urandom;
        @(posedge clk); #1;
      end
      if (!timed_out && is_ld) model_rd = m_load(f3, addr, rdata);
      exp_req = 1'b0; exp_stall = 1'b0; exp_berr = timed_out; exp_rd = model_rd;
      // Bus chatter in DONE must be ignored
      bus.mem_ready = 1'b1; bus.mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    valid_M = 1'b0; Instr_M = '0; bus.mem_ready = 1'b0;
    exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0;
  endtask

  int s0, r0, b0, m0;

  task automatic snap();
    s0 = stall_cyc; r0 = req_cyc; b0 = berr_cyc; m0 = mis_cyc;
  endtask

  initial begin
    rst = 1'b1;
    valid_M = 1'b1; Instr_M = mk(3'b010, LD); ALU_Result_M = 32'h100; Write_Data_M = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(Stall_M), 32'd0);
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_be", 32'(bus.mem_be), 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_rd", Read_Data_M, 32'd0);
    check("rst_berr", 32'(Bus_Err_M), 32'd0);
    ALU_Result_M = 32'h102; #1;
    check("rst_misalign", 32'(Misalign_M), 32'd0);
    valid_M = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    snap();
    run_op(mk(3'b010, LD), 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check("lw_rd", Read_Data_M, 32'hDEADBEEF);
    check("lw_stall_cycles", 32'(stall_cyc - s0), 32'd2);
    check("lw_be", 32'(last_be), 32'hF);
    check("lw_addr", last_addr, 32'h100);

    snap();
    run_op(mk(3'b000, LD), 32'h103, 32'h0, 32'h80FF0000, 0);
    check("lb_rd", Read_Data_M, 32'hFFFFFF80);
    check("lb_be", 32'(last_be), 32'h8);
    run_op(mk(3'b100, LD), 32'h103, 32'h0, 32'h80FF0000, 1);
    check("lbu_rd", Read_Data_M, 32'h00000080);
    run_op(mk(3'b101, LD), 32'h102, 32'h0, 32'h80FF0000, 0);
    check("lhu_rd", Read_Data_M, 32'h000080FF);

    snap();
    run_op(mk(3'b000, ST), 32'h201, 32'h123456AB, 32'h0, 3);
    check("sb_we", 32'(last_we), 32'd1);
    check("sb_be", 32'(last_be), 32'h2);
    check("sb_wdata", last_wdata, 32'hABABABAB);
    check("sb_stall_cycles", 32'(stall_cyc - s0), 32'd5);
    check("sb_rd_kept", Read_Data_M, 32'h000080FF);

    run_op(mk(3'b001, LD), 32'h100, 32'h0, 32'h12348001, 2);
    check("lh_rd", Read_Data_M, 32'hFFFF8001);
    run_op(mk(3'b001, ST), 32'h302, 32'hCAFE5A5A, 32'h0, 0);
    check("sh_be", 32'(last_be), 32'hC);
    check("sh_wdata", last_wdata, 32'h5A5A5A5A);

    snap();
    run_op(mk(3'b010, LD), 32'h102, 32'h0, 32'h0, 0);
    run_op(mk(3'b001, ST), 32'h101, 32'h55, 32'h0, 0);
    check("mis_cycles", 32'(mis_cyc - m0), 32'd2);
    check("mis_req_cycles", 32'(req_cyc - r0), 32'd0);
    check("mis_stall_cycles", 32'(stall_cyc - s0), 32'd0);

    snap();
    run_op(mk(3'b010, LD), 32'h104, 32'h0, 32'h0, -1);
    check("to_req_cycles", 32'(req_cyc - r0), 32'd16);
    check("to_berr_cycles", 32'(berr_cyc - b0), 32'd1);
    check("to_rd_kept", Read_Data_M, 32'hFFFF8001);
    @(posedge clk); #1;
    check("to_berr_cleared", 32'(Bus_Err_M), 32'd0);

    // Reset on the second REQ cycle
    check_en = 1'b0;
    valid_M = 1'b1; Instr_M = mk(3'b010, LD); ALU_Result_M = 32'h108;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_req_before", 32'(bus.mem_req), 32'd1);
    rst = 1'b1; valid_M = 1'b0;
    #1;
    check("rst_req_drop", 32'(bus.mem_req), 32'd0);
    check("rst_stall_drop", 32'(Stall_M), 32'd0);
    model_rd = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    run_op(mk(3'b010, LD), 32'h10C, 32'h0, 32'h13579BDF, 1);
    check("post_rst_lw", Read_Data_M, 32'h13579BDF);

    snap();
    run_op(mk(3'b000, ALU), 32'h100, 32'h0, 32'h0, 0);
    check("add_stall", 32'(stall_cyc - s0), 32'd0);
    check("add_req", 32'(req_cyc - r0), 32'd0);

    repeat (2) @(posedge clk);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
